// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module     : seven_seg_pkg
// Description: Shared types, constants and helpers for the seven-segment
//              scan controller (scan state encoding, digit geometry, digit
//              extraction and leading-zero test).
// Revision   : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam logic [3:0] ANODE_OFF  = 4'b1111;
    localparam int         NUM_DIGITS = 4;
    localparam int         DIGIT_W    = 4;

    // Nibble 'sel' of a packed four-digit value.
    function automatic logic [DIGIT_W-1:0] digit_of(
        input logic [NUM_DIGITS*DIGIT_W-1:0] value,
        input logic [1:0]                    sel
    );
        return value[DIGIT_W*sel +: DIGIT_W];
    endfunction

    // A digit above position 0 is a leading zero when it and every more
    // significant digit are zero. Digit 0 is never suppressed.
    function automatic logic lz_hidden(
        input logic [NUM_DIGITS*DIGIT_W-1:0] value,
        input logic [1:0]                    sel
    );
        logic [NUM_DIGITS*DIGIT_W-1:0] mask;
        mask = {(NUM_DIGITS*DIGIT_W){1'b1}} << (DIGIT_W * sel);
        return (sel != 2'd0) && ((value & mask) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_slot_timer.sv
`default_nettype none
// ============================================================================
// Module     : seg_slot_timer
// Description: Per-digit slot prescaler. Counts 0..REFRESH_DIV-1 once per
//              slot; the first REFRESH_DIV-BLANK_CYC counts are the SHOW
//              phase, the remainder the BLANK phase.
// Ports      : clk, rst_n        - clock, async active-low reset
//              i_clear           - hold the count at 0 (idle / disable)
//              o_show_done       - last SHOW cycle of the slot
//              o_blank_done      - last BLANK cycle (slot terminal count)
// Revision   : 1.0 - initial release
// ============================================================================
module seg_slot_timer #(
    parameter logic [15:0] REFRESH_DIV = 16'd50000,
    parameter logic [15:0] BLANK_CYC   = 16'd500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_show_done,
    output logic o_blank_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] c_show_last = CNT_W'(REFRESH_DIV - BLANK_CYC - 16'd1);
    localparam logic [CNT_W-1:0] c_slot_last = CNT_W'(REFRESH_DIV - 16'd1);

    logic [CNT_W-1:0] r_cnt;

    // Wrapping at REFRESH_DIV-1 makes each slot exactly REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == c_slot_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_show_done  = (r_cnt == c_show_last);
    assign o_blank_done = (r_cnt == c_slot_last);

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : seven_seg_scan_ctrl
// Description: Time-multiplexes four 4-bit digits onto one shared digit
//              decoder, driving active-low anodes with a blanking gap after
//              each digit. The displayed value is double-buffered: a loaded
//              value waits in a pending buffer and becomes active only at a
//              frame boundary (or immediately while idle).
// Ports      : clk, rst_n        - clock, async active-low reset
//              en                - 1 = scan, 0 = all digits dark
//              load_valid/ready  - producer handshake for load_data
//              load_data         - digit3..digit0 as [15:12]..[3:0]
//              num               - registered digit value to the decoder
//              anode_active      - active-low anodes, bit0 = digit 0
//              digit_sel         - current digit slot
//              frame_done        - pulse in the last BLANK cycle of digit 3
// Revision   : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter logic [15:0] REFRESH_DIV = 16'd50000,
    parameter logic [15:0] BLANK_CYC   = 16'd500,
    parameter logic        LZ_BLANK    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  num,
    output logic [3:0]  anode_active,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);

    scan_state_t r_state;
    scan_state_t w_next_state;
    logic [1:0]  r_digit_sel;
    logic [1:0]  w_next_sel;
    logic [3:0]  r_num;
    logic [15:0] r_active;
    logic [15:0] r_pend_data;
    logic        r_pend_valid;

    logic        w_enter_show;
    logic [3:0]  w_anode;
    logic        w_clear;
    logic        w_show_done;
    logic        w_blank_done;
    logic        w_boundary;
    logic        w_transfer;
    logic [15:0] w_next_active;

    // Counter is held at 0 while idle, and cleared in the same cycle en
    // drops so the next enable starts a fresh slot.
    assign w_clear = !en || (r_state == IDLE);

    seg_slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) u_slot_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .o_show_done  (w_show_done),
        .o_blank_done (w_blank_done)
    );

    assign w_boundary    = (r_state == BLANK) && w_blank_done && (r_digit_sel == 2'd3) && en;
    assign w_transfer    = r_pend_valid && (w_boundary || (r_state == IDLE));
    // num is loaded from the value that will be active next cycle, so the
    // first digit of a new frame already reflects a boundary transfer.
    assign w_next_active = w_transfer ? r_pend_data : r_active;

    always_comb begin
        w_next_state = r_state;
        w_next_sel   = r_digit_sel;
        w_enter_show = 1'b0;
        w_anode      = ANODE_OFF;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_next_state = SHOW;
                    w_next_sel   = 2'd0;
                    w_enter_show = 1'b1;
                end
            end
            SHOW: begin
                if (!(LZ_BLANK && lz_hidden(r_active, r_digit_sel))) begin
                    w_anode = ~(4'b0001 << r_digit_sel);
                end
                if (w_show_done) begin
                    w_next_state = BLANK;
                end
            end
            BLANK: begin
                if (w_blank_done) begin
                    w_next_state = SHOW;
                    w_next_sel   = r_digit_sel + 2'd1;
                    w_enter_show = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        // Disable overrides any transition, including the frame boundary.
        if (!en) begin
            w_next_state = IDLE;
            w_next_sel   = 2'd0;
            w_enter_show = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_digit_sel <= 2'd0;
            r_num       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_digit_sel <= w_next_sel;
            if (w_enter_show) begin
                r_num <= digit_of(w_next_active, w_next_sel);
            end
        end
    end

    // Capture and transfer are mutually exclusive: capture needs an empty
    // buffer, transfer needs a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active     <= '0;
            r_pend_data  <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_transfer) begin
            r_active     <= r_pend_data;
            r_pend_valid <= 1'b0;
        end else if (load_valid && !r_pend_valid) begin
            r_pend_data  <= load_data;
            r_pend_valid <= 1'b1;
        end
    end

    assign load_ready   = !r_pend_valid;
    assign num          = r_num;
    assign anode_active = w_anode;
    assign digit_sel    = r_digit_sel;
    assign frame_done   = w_boundary;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_seven_seg_scan_ctrl
// Description: Directed self-checking bench for seven_seg_scan_ctrl with
//              REFRESH_DIV=8, BLANK_CYC=2. A second instance with LZ_BLANK=0
//              shares all inputs to contrast leading-zero handling.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load_valid;
    logic [15:0] load_data;

    logic        load_ready,  load_ready2;
    logic [3:0]  num,         num2;
    logic [3:0]  anode_active, anode_active2;
    logic [1:0]  digit_sel,   digit_sel2;
    logic        frame_done,  frame_done2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV (16'd8),
        .BLANK_CYC   (16'd2),
        .LZ_BLANK    (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .num          (num),
        .anode_active (anode_active),
        .digit_sel    (digit_sel),
        .frame_done   (frame_done)
    );

    seven_seg_scan_ctrl #(
        .REFRESH_DIV (16'd8),
        .BLANK_CYC   (16'd2),
        .LZ_BLANK    (1'b0)
    ) dut_nolz (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready2),
        .num          (num2),
        .anode_active (anode_active2),
        .digit_sel    (digit_sel2),
        .frame_done   (frame_done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks cycles k0..k1 of a 32-cycle frame: 6 SHOW + 2 BLANK per digit.
    // 'shown' marks which digits the LZ_BLANK=1 instance lights up.
    // Vector: {an, an_nolz, num, num2, sel, sel2, fd, fd2, rdy, rdy2}.
    task automatic frame_check(input string tag, input logic [15:0] val, input logic [3:0] shown,
                               input int k0, input int k1, input logic exp_rdy);
        for (int k = k0; k <= k1; k++) begin
            int          slot;
            int          pos;
            logic [3:0]  onehot;
            logic [3:0]  an_full;
            logic [3:0]  an_lz;
            logic [15:0] shifted;
            logic        fd;
            logic [23:0] exp_v;
            logic [23:0] obs_v;
            slot    = k / 8;
            pos     = k % 8;
            onehot  = 4'b0001 << slot;
            an_full = (pos < 6) ? ~onehot : 4'b1111;
            an_lz   = (pos < 6 && shown[slot]) ? ~onehot : 4'b1111;
            shifted = val >> (4 * slot);
            fd      = (k == 31);
            exp_v   = {an_lz, an_full, shifted[3:0], shifted[3:0], slot[1:0], slot[1:0],
                       fd, fd, exp_rdy, exp_rdy};
            obs_v   = {anode_active, anode_active2, num, num2, digit_sel, digit_sel2,
                       frame_done, frame_done2, load_ready, load_ready2};
            chk($sformatf("%s k=%0d", tag, k), {8'h0, obs_v}, {8'h0, exp_v});
            tick();
        end
    endtask

    task automatic start_load(input logic [15:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp_q[$];
        logic [15:0] shown_val;
        logic        cap;
        int          n_cap;

        rst_n      = 1'b0;
        en         = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        tick();
        tick();

        // Reset state
        chk("rst_anode", anode_active, 4'b1111);
        chk("rst_num",   num,          4'h0);
        chk("rst_sel",   digit_sel,    2'd0);
        chk("rst_ready", load_ready,   1'b1);
        chk("rst_fd",    frame_done,   1'b0);
        rst_n = 1'b1;
        tick();
        chk("idle_anode", anode_active, 4'b1111);

        // 1: load in IDLE, then scan
        start_load(16'h1234);
        chk("t1_ready_low", load_ready, 1'b0);
        tick();
        chk("t1_ready_high", load_ready, 1'b1);
        en = 1'b1;
        tick();
        frame_check("t1a", 16'h1234, 4'b1111, 0, 31, 1'b1);
        frame_check("t1b", 16'h1234, 4'b1111, 0, 31, 1'b1);

        // 2: load mid-frame waits for the boundary
        start_load(16'hABCD);
        frame_check("t2_old", 16'h1234, 4'b1111, 1, 31, 1'b0);
        frame_check("t2_new", 16'hABCD, 4'b1111, 0, 31, 1'b1);

        // 3: leading-zero blanking
        start_load(16'h0005);
        frame_check("t3_old", 16'hABCD, 4'b1111, 1, 31, 1'b0);
        start_load(16'h0105);
        frame_check("t3_0005", 16'h0005, 4'b0001, 1, 31, 1'b0);
        frame_check("t3_0105", 16'h0105, 4'b0111, 0, 31, 1'b1);

        // 4: drop en during digit 2 SHOW
        frame_check("t4_pre", 16'h0105, 4'b0111, 0, 16, 1'b1);
        en = 1'b0;
        chk("t4_still_on", anode_active, 4'b1011);
        chk("t4_fd_drop",  frame_done,   1'b0);
        tick();
        chk("t4_off_anode", anode_active, 4'b1111);
        chk("t4_off_nolz",  anode_active2, 4'b1111);
        chk("t4_off_sel",   digit_sel,    2'd0);
        chk("t4_off_fd",    frame_done,   1'b0);
        tick();
        chk("t4_idle_anode", anode_active, 4'b1111);
        en = 1'b1;
        chk("t4_en_anode", anode_active, 4'b1111);
        tick();
        frame_check("t4_resume", 16'h0105, 4'b0111, 0, 31, 1'b1);

        // 5: reset mid-SHOW with a pending value
        start_load(16'h9999);
        frame_check("t5_pre", 16'h0105, 4'b0111, 1, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_anode", anode_active, 4'b1111);
        chk("t5_rst_ready", load_ready,   1'b1);
        chk("t5_rst_sel",   digit_sel,    2'd0);
        chk("t5_rst_num",   num,          4'h0);
        tick();
        rst_n = 1'b1;
        chk("t5_rel_anode", anode_active, 4'b1111);
        tick();
        frame_check("t5_zero", 16'h0000, 4'b0001, 0, 31, 1'b1);

        // 6: valid held high, one capture per frame, scoreboarded
        exp_q.push_back(16'h0000);
        n_cap      = 0;
        load_valid = 1'b1;
        load_data  = 16'h2468;
        for (int f = 0; f < 4; f++) begin
            shown_val = 16'h0000;
            for (int k = 0; k < 32; k++) begin
                cap = load_valid && load_ready;
                if (k % 8 == 0) shown_val[4*(k/8) +: 4] = num;
                if (cap) begin
                    exp_q.push_back(load_data);
                    n_cap++;
                end
                tick();
                if (cap) load_data = load_data + 16'h1111;
            end
            chk($sformatf("t6_frame%0d", f), shown_val, exp_q.pop_front());
        end
        load_valid = 1'b0;
        chk("t6_captures", n_cap, 4);
        frame_check("t6_last", 16'h579B, 4'b1111, 0, 30, 1'b1);

        // 7: capture in the boundary cycle waits a whole frame
        load_valid = 1'b1;
        load_data  = 16'h4321;
        chk("t7_fd",    frame_done, 1'b1);
        chk("t7_ready", load_ready, 1'b1);
        tick();
        load_valid = 1'b0;
        frame_check("t7_wait", 16'h579B, 4'b1111, 0, 31, 1'b0);
        frame_check("t7_new",  16'h4321, 4'b1111, 0, 31, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
